// File: rtl/spi_rx.sv
`timescale 1ns/1ps
// spi_rx: SPI mode-0 slave receiver, MSB first, oversampled in the clk domain.
// sclk, ss and sdi pass through two-flop synchronisers; sclk and ss get a
// third flop for edge detection. Each completed WIDTH-bit word is presented
// on dat with a one-cycle vld strobe; a frame that ends mid-word gives a
// one-cycle err strobe instead.
// Optional feature macro: SPI_RX_ECHO_EN adds an sdo port that echoes the
// previously completed word, MSB first, during the next frame.
module spi_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss,
  input  logic             sdi,
  output logic [WIDTH-1:0] dat,
  output logic             vld,
  output logic             err,
  output logic             busy
`ifdef SPI_RX_ECHO_EN
  ,
  output logic             sdo
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // synchroniser and edge-detect stages
  logic sclk_p0, sclk_p1, sclk_p2;
  logic ss_p0, ss_p1, ss_p2;
  logic sdi_p0, sdi_p1;
  // goes all-ones once the synchronisers hold real input samples
  logic [1:0] flush;

  logic armed;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nx;

  logic sclk_rise;
  logic ss_fall;
  logic ss_rise;
  logic ss_lo;

  // Stage p0/p1: two-flop synchronisers; p2: previous sample for edges.
  // Idle values on reset so that no edge is seen out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      ss_p0   <= 1'b1;
      ss_p1   <= 1'b1;
      ss_p2   <= 1'b1;
      sdi_p0  <= 1'b0;
      sdi_p1  <= 1'b0;
      flush   <= 2'b00;
    end else begin
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      ss_p0   <= ss;
      ss_p1   <= ss_p0;
      ss_p2   <= ss_p1;
      sdi_p0  <= sdi;
      sdi_p1  <= sdi_p0;
      flush   <= {flush[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign ss_fall   = ~ss_p1 & ss_p2;
  assign ss_rise   = ss_p1 & ~ss_p2;
  assign ss_lo     = ~ss_p1;
  assign shift_nx  = {shift[WIDTH-2:0], sdi_p1};

  // Arm only on a genuine high ss sample; the reset value of the
  // synchroniser must not count, or a reset mid-frame would arm early and
  // receive the tail of that frame as a misaligned word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (flush[1] && ss_p1) begin
      armed <= 1'b1;
    end
  end

  // Receive: ss rise has priority over a coincident sclk rise, so err is
  // judged on the count before that edge and the edge itself is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      shift <= '0;
      dat   <= '0;
      vld   <= 1'b0;
      err   <= 1'b0;
    end else begin
      vld <= 1'b0;
      err <= 1'b0;
      if (armed) begin
        if (ss_rise) begin
          err <= (cnt != '0);
          cnt <= '0;
        end else if (ss_fall) begin
          cnt   <= '0;
          shift <= '0;
        end else if (ss_lo && sclk_rise) begin
          shift <= shift_nx;
          if (cnt == LAST) begin
            dat <= shift_nx;
            vld <= 1'b1;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

  assign busy = armed & ss_lo;

`ifdef SPI_RX_ECHO_EN
  logic sclk_fall;
  logic [WIDTH-1:0] echo;
  logic [WIDTH-1:0] esh;

  assign sclk_fall = ~sclk_p1 & sclk_p2;

  // Echo word capture and its per-frame output shifter; sdo changes on
  // sclk falling edges so the master samples it on the next rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo <= '0;
      esh  <= '0;
    end else begin
      if (vld) begin
        echo <= dat;
      end
      if (armed && ss_fall) begin
        esh <= echo;
      end else if (armed && ss_lo && sclk_fall) begin
        esh <= {esh[WIDTH-2:0], 1'b0};
      end
    end
  end

  // In the ss-fall cycle the shifter is still loading, so take the MSB
  // straight from the echo word.
  assign sdo = busy & (ss_fall ? echo[WIDTH-1] : esh[WIDTH-1]);
`endif

endmodule
